// File: rtl/switch_buf.sv
// switch_buf: buffered N-core vector switch with one FIFO per (source, destination) pair.
// Optional feature: define SWITCH_BUF_LOOPBACK_EN to give each core a FIFO to itself.
module switch_buf #(
   parameter int CORE_SIZE      = 4,
   parameter int WIDTH          = 16,
   parameter int DEPTH          = 4,
   parameter int CORE_ADDR_SIZE = $clog2(CORE_SIZE)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CORE_SIZE-1:0]      send_ready,
   input  logic [CORE_ADDR_SIZE-1:0] send_core_idx [CORE_SIZE],
   input  logic [31:0]               send_data     [CORE_SIZE][WIDTH],
   output logic [CORE_SIZE-1:0]      send_ok,
   input  logic [CORE_SIZE-1:0]      recv_request,
   input  logic [CORE_ADDR_SIZE-1:0] recv_core_idx [CORE_SIZE],
   output logic [CORE_SIZE-1:0]      recv_ready,
   output logic [31:0]               recv_data     [CORE_SIZE][WIDTH],
   output logic [CORE_SIZE-1:0]      recv_pending  [CORE_SIZE]
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
`ifdef SWITCH_BUF_LOOPBACK_EN
   localparam bit LOOPBACK = 1'b1;
`else
   localparam bit LOOPBACK = 1'b0;
`endif
   logic [CW-1:0]             r_cnt  [CORE_SIZE][CORE_SIZE];
   logic [PW-1:0]             r_wr   [CORE_SIZE][CORE_SIZE];
   logic [PW-1:0]             r_rd   [CORE_SIZE][CORE_SIZE];
   logic [31:0]               r_mem  [CORE_SIZE][CORE_SIZE][DEPTH][WIDTH];
   logic [CORE_ADDR_SIZE-1:0] w_sdst [CORE_SIZE];
   logic [CORE_ADDR_SIZE-1:0] w_rsrc [CORE_SIZE];
   logic [CORE_SIZE-1:0]      w_sin;
   logic [CORE_SIZE-1:0]      w_rin;
   logic [CORE_SIZE-1:0]      w_enq  [CORE_SIZE];
   logic [CORE_SIZE-1:0]      w_deq  [CORE_SIZE];

   // Validate indices (range and self-pair) and clamp them so storage lookups never go out of range.
   always_comb begin
      for (int i = 0; i < CORE_SIZE; i++) begin
         w_sin[i]  = 32'(send_core_idx[i]) < CORE_SIZE && (LOOPBACK || 32'(send_core_idx[i]) != i);
         w_rin[i]  = 32'(recv_core_idx[i]) < CORE_SIZE && (LOOPBACK || 32'(recv_core_idx[i]) != i);
         w_sdst[i] = 32'(send_core_idx[i]) < CORE_SIZE ? send_core_idx[i] : '0;
         w_rsrc[i] = 32'(recv_core_idx[i]) < CORE_SIZE ? recv_core_idx[i] : '0;
      end
   end

   // Each port is judged only on its own pair FIFO's registered count, so no recv-to-send path exists.
   always_comb begin
      for (int i = 0; i < CORE_SIZE; i++) begin
         send_ok[i]    = reset && send_ready[i] && w_sin[i] && r_cnt[i][w_sdst[i]] != CW'(DEPTH);
         recv_ready[i] = reset && recv_request[i] && w_rin[i] && r_cnt[w_rsrc[i]][i] != '0;
      end
   end

   // Per-pair enqueue/dequeue strobes and pending flags; index order is [source][destination].
   always_comb begin
      for (int s = 0; s < CORE_SIZE; s++) begin
         for (int d = 0; d < CORE_SIZE; d++) begin
            w_enq[s][d]        = send_ok[s] && w_sdst[s] == CORE_ADDR_SIZE'(d);
            w_deq[s][d]        = recv_ready[d] && w_rsrc[d] == CORE_ADDR_SIZE'(s);
            recv_pending[d][s] = (LOOPBACK || s != d) && r_cnt[s][d] != '0;
         end
      end
   end

   // Present the head of the selected FIFO; meaningful only while recv_ready is high.
   always_comb begin
      for (int d = 0; d < CORE_SIZE; d++) begin
         for (int l = 0; l < WIDTH; l++) begin
            recv_data[d][l] = r_mem[w_rsrc[d]][d][r_rd[w_rsrc[d]][d]][l];
         end
      end
   end

   // Pointer and occupancy update; reset empties every FIFO at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < CORE_SIZE; s++) begin
            for (int d = 0; d < CORE_SIZE; d++) begin
               r_cnt[s][d] <= '0;
               r_wr[s][d]  <= '0;
               r_rd[s][d]  <= '0;
            end
         end
      end else begin
         for (int s = 0; s < CORE_SIZE; s++) begin
            for (int d = 0; d < CORE_SIZE; d++) begin
               if (w_enq[s][d]) r_wr[s][d] <= r_wr[s][d] == PW'(DEPTH - 1) ? '0 : r_wr[s][d] + PW'(1);
               if (w_deq[s][d]) r_rd[s][d] <= r_rd[s][d] == PW'(DEPTH - 1) ? '0 : r_rd[s][d] + PW'(1);
               r_cnt[s][d] <= r_cnt[s][d] + CW'(w_enq[s][d]) - CW'(w_deq[s][d]);
            end
         end
      end
   end

   // Payload storage is never cleared; stale entries become unreachable once counts reset.
   always_ff @(posedge clock) begin
      for (int s = 0; s < CORE_SIZE; s++) begin
         for (int d = 0; d < CORE_SIZE; d++) begin
            if (w_enq[s][d]) begin
               for (int l = 0; l < WIDTH; l++) r_mem[s][d][r_wr[s][d]][l] <= send_data[s][l];
            end
         end
      end
   end
endmodule
